multi_channel_snapshot_averager: RTL and testbench

- Parametrised successor to the fixed X/Y/Z/T averaging-and-one-second-latch logic in the accelerometer path.
- Accepts a channel-tagged sample stream from the SPI command driver and keeps a running signed mean per channel over 2^LOG2_DEPTH samples.
- At a programmable period, publishes a snapshot of all channel means to the UART formatter over a valid/ready handshake, with sequence numbering and overrun detection.

---
 rtl/multi_channel_snapshot_averager_pkg.sv | 17 +
 rtl/multi_channel_snapshot_averager_channel_accumulator.sv | 44 ++++
 rtl/multi_channel_snapshot_averager.sv | 84 ++++++++
 tb/tb_multi_channel_snapshot_averager.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multi_channel_snapshot_averager_pkg.sv
// multi_channel_snapshot_averager_pkg: shared constants, handshake state encodings and mean rounding offset.
// Optional feature macro MCSA_ROUND_EN: when defined, means round half up instead of flooring.
package multi_channel_snapshot_averager_pkg;
   localparam int DEF_DATA_W = 12;
   localparam int DEF_LOG2_DEPTH = 7;
   localparam int DEF_PERIOD_CYCLES = 100_000_000;
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL = 1'b1;
`ifdef MCSA_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif
   function automatic int round_offset(input int log2_depth);
      return (ROUND_EN && log2_depth > 0) ? (1 << (log2_depth - 1)) : 0;
   endfunction
endpackage

// File: rtl/multi_channel_snapshot_averager_channel_accumulator.sv
// multi_channel_snapshot_averager_channel_accumulator: running sum over 2^LOG2_DEPTH samples and mean register for one channel.
// Ports: clk, reset (sync, active high), add_en (accept sample), sample (signed), mean (signed, last completed average).
module multi_channel_snapshot_averager_channel_accumulator
   import multi_channel_snapshot_averager_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     add_en,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [DATA_W-1:0] mean
);
   localparam int AW = DATA_W + LOG2_DEPTH;
   localparam int CW = LOG2_DEPTH + 1;
   localparam logic [CW-1:0] LAST = CW'((1 << LOG2_DEPTH) - 1);
   localparam logic signed [AW-1:0] OFF = AW'(round_offset(LOG2_DEPTH));
   logic signed [AW-1:0] acc_q, acc_d, sum, rnd;
   logic [CW-1:0] cnt_q, cnt_d;
   logic signed [DATA_W-1:0] mean_q, mean_d;
   logic done;
   assign sum = acc_q + AW'(sample);
   assign rnd = sum + OFF;
   assign mean = mean_q;
   // The sample that completes the block is folded into the mean in the same edge that clears the sum.
   always_comb begin
      done = add_en && cnt_q == LAST;
      acc_d = !add_en ? acc_q : done ? '0 : sum;
      cnt_d = !add_en ? cnt_q : done ? '0 : cnt_q + CW'(1);
      mean_d = done ? DATA_W'(rnd >>> LOG2_DEPTH) : mean_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
         mean_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         mean_q <= mean_d;
      end
   end
endmodule

// File: rtl/multi_channel_snapshot_averager.sv
// multi_channel_snapshot_averager: per-channel running means, published as periodic sequenced snapshots over valid/ready.
// Ports: clk, reset (sync, active high); sample_valid/sample_chan/sample_data (tagged sample stream, never stalled);
// snap_valid/snap_ready/snap_data/snap_seq (snapshot handshake); overrun (sticky); bad_chan_err (one-cycle pulse).
// Build option MCSA_ROUND_EN selects round-half-up means (see package).
module multi_channel_snapshot_averager
   import multi_channel_snapshot_averager_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W = 2,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
   parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
   parameter int SEQ_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_valid,
   input  logic [CH_W-1:0]          sample_chan,
   input  logic signed [DATA_W-1:0] sample_data,
   output logic                     snap_valid,
   input  logic                     snap_ready,
   output logic [NUM_CH*DATA_W-1:0] snap_data,
   output logic [SEQ_W-1:0]         snap_seq,
   output logic                     overrun,
   output logic                     bad_chan_err
);
   localparam int PW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
   logic [NUM_CH-1:0] add_en;
   logic [NUM_CH*DATA_W-1:0] means;
   logic chan_ok, tick, load;
   logic [PW-1:0] per_q, per_d;
   logic [0:0] state_q, state_d;
   logic [NUM_CH*DATA_W-1:0] data_q, data_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic ovr_q, ovr_d, bad_q, bad_d;
   assign chan_ok = int'(sample_chan) < NUM_CH;
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign add_en[k] = sample_valid && sample_chan == CH_W'(k);
      multi_channel_snapshot_averager_channel_accumulator #(
         .DATA_W(DATA_W),
         .LOG2_DEPTH(LOG2_DEPTH)
      ) u_channel_accumulator (
         .clk(clk),
         .reset(reset),
         .add_en(add_en[k]),
         .sample(sample_data),
         .mean(means[k*DATA_W +: DATA_W])
      );
   end
   // A tick loads when the slot is free or being drained this cycle; otherwise the held snapshot wins and overrun latches.
   always_comb begin
      tick = per_q == PER_LAST;
      load = tick && (state_q == ST_EMPTY || snap_ready);
      per_d = tick ? '0 : per_q + PW'(1);
      state_d = load ? ST_FULL : snap_ready ? ST_EMPTY : state_q;
      data_d = load ? means : data_q;
      seq_d = load ? seq_q + SEQ_W'(1) : seq_q;
      ovr_d = ovr_q || (tick && !load);
      bad_d = sample_valid && !chan_ok;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         per_q <= '0;
         state_q <= ST_EMPTY;
         data_q <= '0;
         seq_q <= '0;
         ovr_q <= 1'b0;
         bad_q <= 1'b0;
      end else begin
         per_q <= per_d;
         state_q <= state_d;
         data_q <= data_d;
         seq_q <= seq_d;
         ovr_q <= ovr_d;
         bad_q <= bad_d;
      end
   end
   assign snap_valid = state_q == ST_FULL;
   assign snap_data = data_q;
   assign snap_seq = seq_q;
   assign overrun = ovr_q;
   assign bad_chan_err = bad_q;
endmodule

// File: tb/tb_multi_channel_snapshot_averager.sv
// tb_multi_channel_snapshot_averager: directed scenarios plus random traffic checked against a queue-based model.
module tb_multi_channel_snapshot_averager;
   localparam int NCH = 4, CHW = 3, DW = 12, L2 = 2, PER = 64, SW = 8;
`ifdef MCSA_ROUND_EN
   localparam int OFF = 2;
   localparam int EXP_CH1 = 2;
`else
   localparam int OFF = 0;
   localparam int EXP_CH1 = 1;
`endif
   logic clk = 0, reset = 1, sample_valid = 0, snap_ready = 0;
   logic [CHW-1:0] sample_chan = '0;
   logic signed [DW-1:0] sample_data = '0;
   logic snap_valid, overrun, bad_chan_err;
   logic [NCH*DW-1:0] snap_data;
   logic [SW-1:0] snap_seq;
   int checks = 0, fails = 0;
   bit chk_en = 0;
   int m_per, m_seq;
   bit m_valid, m_ovr, m_bad;
   int m_mean[NCH], m_snap[NCH];
   int q[NCH][$];

   always #5 clk = ~clk;

   multi_channel_snapshot_averager #(
      .NUM_CH(NCH), .CH_W(CHW), .DATA_W(DW), .LOG2_DEPTH(L2), .PERIOD_CYCLES(PER), .SEQ_W(SW)
   ) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_chan(sample_chan),
      .sample_data(sample_data), .snap_valid(snap_valid), .snap_ready(snap_ready),
      .snap_data(snap_data), .snap_seq(snap_seq), .overrun(overrun), .bad_chan_err(bad_chan_err)
   );

   function automatic int floor_div(input int s, input int d);
      int r = s / d;
      if ((s % d) != 0 && s < 0) r--;
      return r;
   endfunction

   function automatic int field(input int k);
      return int'($signed(snap_data[k*DW +: DW]));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model state after a clock edge, from the inputs that edge sampled.
   task automatic model_update();
      bit tick;
      int c;
      if (reset) begin
         m_per = 0; m_seq = 0; m_valid = 0; m_ovr = 0; m_bad = 0;
         for (int k = 0; k < NCH; k++) begin
            m_mean[k] = 0; m_snap[k] = 0; q[k].delete();
         end
      end else begin
         tick = m_per == PER - 1;
         if (tick && (!m_valid || snap_ready)) begin
            m_valid = 1; m_seq = (m_seq + 1) % (1 << SW); m_snap = m_mean;
         end else if (tick) m_ovr = 1;
         else if (snap_ready) m_valid = 0;
         m_per = (m_per + 1) % PER;
         m_bad = sample_valid && sample_chan >= NCH;
         if (sample_valid && sample_chan < NCH) begin
            c = int'(sample_chan);
            q[c].push_back(int'(sample_data));
            if (q[c].size() == (1 << L2)) begin
               m_mean[c] = floor_div(q[c].sum() + OFF, 1 << L2);
               q[c].delete();
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic send(input int ch, input int d);
      sample_valid = 1; sample_chan = CHW'(ch); sample_data = DW'(d);
      step();
      sample_valid = 0;
   endtask

   task automatic do_reset();
      reset = 1; step(); step(); reset = 0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!snap_valid && n < 300) begin step(); n++; end
      chk({name, " snap_valid"}, int'(snap_valid), 1);
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("snap_valid", int'(snap_valid), int'(m_valid));
      chk("snap_seq", int'(snap_seq), m_seq);
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("bad_chan_err", int'(bad_chan_err), int'(m_bad));
      for (int k = 0; k < NCH; k++) chk($sformatf("snap_data[%0d]", k), field(k), m_snap[k]);
   end

   initial begin
      int n;
      reset = 1; step(); step(); chk_en = 1;
      chk("rst snap_valid", int'(snap_valid), 0);
      chk("rst snap_data nonzero", int'(|snap_data), 0);
      chk("rst snap_seq", int'(snap_seq), 0);
      chk("rst overrun", int'(overrun), 0);
      chk("rst bad_chan_err", int'(bad_chan_err), 0);
      reset = 0; snap_ready = 1;
      send(0, 10); send(0, 20); send(0, 30); send(0, 40);
      send(1, 1); send(1, 2); send(1, 2); send(1, 2);
      send(2, -3); send(2, -4); send(2, -4); send(2, -4);
      wait_valid("basic");
      chk("basic ch0", field(0), 25);
      chk("basic ch1", field(1), EXP_CH1);
      chk("basic ch2", field(2), -4);
      chk("basic ch3", field(3), 0);
      chk("basic seq", int'(snap_seq), 1);
      snap_ready = 0; do_reset();
      send(0, 10); send(0, 20); send(0, 30); send(0, 40);
      wait_valid("bp first");
      repeat (4) send(0, 100);
      n = 0;
      while (!overrun && n < 300) begin step(); n++; end
      chk("bp overrun", int'(overrun), 1);
      chk("bp valid", int'(snap_valid), 1);
      chk("bp seq", int'(snap_seq), 1);
      chk("bp ch0 held", field(0), 25);
      snap_ready = 1; step(); snap_ready = 0;
      chk("bp release valid", int'(snap_valid), 0);
      chk("bp overrun sticky", int'(overrun), 1);
      do_reset();
      wait_valid("sim first");
      repeat (4) send(1, 50);
      n = 0;
      while (m_per != PER - 1 && n < 200) begin step(); n++; end
      snap_ready = 1; step(); snap_ready = 0;
      chk("sim valid", int'(snap_valid), 1);
      chk("sim seq", int'(snap_seq), 2);
      chk("sim overrun", int'(overrun), 0);
      chk("sim ch1", field(1), 50);
      do_reset();
      repeat (3) send(3, 100);
      do_reset();
      snap_ready = 1;
      repeat (4) send(3, 8);
      wait_valid("rst mid");
      chk("rst mid ch3", field(3), 8);
      chk("rst mid seq", int'(snap_seq), 1);
      send(5, 123);
      chk("bad pulse", int'(bad_chan_err), 1);
      step();
      chk("bad clear", int'(bad_chan_err), 0);
      for (int i = 0; i < 17000; i++) begin
         snap_ready = $urandom_range(0, 9) < 3;
         sample_valid = 1'($urandom_range(0, 1));
         sample_chan = $urandom_range(0, 7) < 6 ? CHW'($urandom_range(0, 3)) : CHW'($urandom_range(4, 7));
         sample_data = DW'($urandom_range(0, 4095));
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
